// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus transmit sequencer feeding a TxD serializer.
// Bytes pushed with WREN are buffered in a circular FIFO and launched one at a
// time with a single-cycle TXSTART pulse. The block waits for TXDONE and then
// an optional idle gap before it launches the next byte.
// Optional feature: define UART_TX_FIFO_OVF_EN to add a sticky OVERFLOW flag
// with an OVFCLR clear input.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AWIDTH    = 4,
    parameter int GAPCYCLES = 1
) (
    input  logic              CLOCK,
    input  logic              NRESET,
    input  logic [7:0]        WRDATA,
    input  logic              WREN,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic [7:0]        TXDATA,
    output logic              TXSTART,
    input  logic              TXBUSY,
    input  logic              TXDONE,
    output logic              IDLE
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic              OVERFLOW,
    input  logic              OVFCLR
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Gap counter only ever holds values up to GAPCYCLES-1.
    localparam int GW = (GAPCYCLES > 1) ? $clog2(GAPCYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     gapcnt;
    logic [GW-1:0]     gapcnt_nxt;

    logic [7:0]        mem [DEPTH];
    logic [AWIDTH-1:0] wrptr;
    logic [AWIDTH-1:0] rdptr;
    logic [AWIDTH:0]   count;
    logic [7:0]        txdata;
    logic              txstart;

    logic              wr_ok;
    logic              pop;

    // FULL is taken from the registered count, so a same-cycle pop never
    // makes room for a write that arrives while full.
    assign FULL    = (count == (AWIDTH+1)'(DEPTH));
    assign EMPTY   = (count == '0);
    assign COUNT   = count;
    assign TXDATA  = txdata;
    assign TXSTART = txstart;
    assign IDLE    = EMPTY && (state == S_IDLE);
    assign wr_ok   = WREN && !FULL;

    // Next-state logic for the launch sequencer; pop occurs only on IDLE->WAIT.
    always_comb begin
        state_nxt  = state;
        gapcnt_nxt = gapcnt;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!EMPTY && !TXBUSY) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (TXDONE) begin
                    if (GAPCYCLES > 0) begin
                        state_nxt  = S_GAP;
                        gapcnt_nxt = GW'(GAPCYCLES - 1);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gapcnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gapcnt_nxt = gapcnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and gap counter registers.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            state  <= S_IDLE;
            gapcnt <= '0;
        end else begin
            state  <= state_nxt;
            gapcnt <= gapcnt_nxt;
        end
    end

    // FIFO storage; contents are deliberately left unreset.
    always_ff @(posedge CLOCK) begin
        if (wr_ok) begin
            mem[wrptr] <= WRDATA;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks writes against pops.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop) begin
                rdptr <= rdptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch registers: data held until the next pop, start is a one-cycle pulse.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            txdata  <= 8'h00;
            txstart <= 1'b0;
        end else begin
            txstart <= pop;
            if (pop) begin
                txdata <= mem[rdptr];
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky drop indicator; a new overflow takes priority over a clear.
    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            OVERFLOW <= 1'b0;
        end else if (WREN && FULL) begin
            OVERFLOW <= 1'b1;
        end else if (OVFCLR) begin
            OVERFLOW <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: directed writes, a behavioural TxD stand-in,
// and an in-order byte scoreboard. Honours UART_TX_FIFO_OVF_EN when defined.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int AWIDTH = 4;
    localparam int GAP    = 1;
    localparam int FRAME  = 30;

    logic              CLOCK;
    logic              NRESET;
    logic [7:0]        WRDATA;
    logic              WREN;
    logic              FULL;
    logic              EMPTY;
    logic [AWIDTH:0]   COUNT;
    logic [7:0]        TXDATA;
    logic              TXSTART;
    logic              TXBUSY;
    logic              TXDONE;
    logic              IDLE;
`ifdef UART_TX_FIFO_OVF_EN
    logic              OVERFLOW;
    logic              OVFCLR;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned starts = 0;
    int unsigned busy_cnt = 0;
    int unsigned peak = 0;
    int unsigned s0;
    logic        prev_start = 1'b0;
    logic [7:0]  expq[$];
    logic [7:0]  rxq[$];

    uart_tx_fifo #(
        .DEPTH     (DEPTH),
        .AWIDTH    (AWIDTH),
        .GAPCYCLES (GAP)
    ) dut (
        .CLOCK   (CLOCK),
        .NRESET  (NRESET),
        .WRDATA  (WRDATA),
        .WREN    (WREN),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT),
        .TXDATA  (TXDATA),
        .TXSTART (TXSTART),
        .TXBUSY  (TXBUSY),
        .TXDONE  (TXDONE),
        .IDLE    (IDLE)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .OVERFLOW (OVERFLOW),
        .OVFCLR   (OVFCLR)
`endif
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 2 time units after it.
    task automatic step();
        @(posedge CLOCK);
        #2;
        if (32'(COUNT) > peak) peak = 32'(COUNT);
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        WREN   = 1'b1;
        WRDATA = b;
        step();
        WREN   = 1'b0;
        if (keep) expq.push_back(b);
    endtask

    task automatic compare_rx();
        check("rx_count", rxq.size(), expq.size());
        while (rxq.size() > 0 && expq.size() > 0) begin
            check("rx_byte", rxq.pop_front(), expq.pop_front());
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic wait_idle(input int unsigned maxc);
        bit ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            if (IDLE && !TXBUSY) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("idle_timeout", ok, 1);
    endtask

    // TxD stand-in: captures each launched byte, stays busy for FRAME cycles,
    // then emits a one-cycle TXDONE.
    initial begin
        TXBUSY = 1'b0;
        TXDONE = 1'b0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!NRESET) begin
                TXBUSY     = 1'b0;
                TXDONE     = 1'b0;
                busy_cnt   = 0;
                prev_start = 1'b0;
            end else begin
                TXDONE = 1'b0;
                if (prev_start) check("start_width", TXSTART, 0);
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        TXBUSY = 1'b0;
                        TXDONE = 1'b1;
                    end
                end
                if (TXSTART && !prev_start) begin
                    check("start_while_busy", TXBUSY, 0);
                    starts++;
                    rxq.push_back(TXDATA);
                    TXBUSY   = 1'b1;
                    busy_cnt = FRAME;
                end
                prev_start = TXSTART;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        bit ok;
        NRESET = 1'b0;
        WREN   = 1'b0;
        WRDATA = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
        OVFCLR = 1'b0;
`endif
        repeat (2) @(posedge CLOCK);
        #2;
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_count", COUNT, 0);
        check("rst_txstart", TXSTART, 0);
        check("rst_txdata", TXDATA, 8'h00);
        check("rst_idle", IDLE, 1);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_overflow", OVERFLOW, 0);
`endif
        NRESET = 1'b1;
        step();

        // Single byte: written at edge k, launched at edge k+1.
        s0 = starts;
        push(8'hAA, 1);
        check("sb_empty", EMPTY, 0);
        check("sb_count", COUNT, 1);
        check("sb_start_early", TXSTART, 0);
        step();
        check("sb_start", TXSTART, 1);
        check("sb_data", TXDATA, 8'hAA);
        check("sb_count_pop", COUNT, 0);
        check("sb_idle_busy", IDLE, 0);
        step();
        check("sb_pulse_end", TXSTART, 0);
        check("sb_data_hold", TXDATA, 8'hAA);
        ok = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            if (TXDONE) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("done_timeout", ok, 1);
        step();
        for (int i = 0; i < GAP; i++) begin
            check("gap_idle_low", IDLE, 0);
            step();
        end
        check("gap_idle_high", IDLE, 1);
        compare_rx();
        check("sb_starts", starts - s0, 1);

        // Burst of 10 back-to-back writes.
        s0   = starts;
        peak = 0;
        for (int i = 0; i < 10; i++) push(8'(8'hAA + i), 1);
        wait_idle(10 * (FRAME + GAP + 5) + 20);
        check("burst_peak", peak, 9);
        check("burst_starts", starts - s0, 10);
        compare_rx();

        // Overflow: 18 writes into a 16-deep FIFO; the last byte is dropped.
        s0 = starts;
        for (int i = 0; i < 18; i++) begin
            push(8'(i), i < 17);
            if (i == 15) check("ovf_full_16", FULL, 0);
            if (i == 16) begin
                check("ovf_full_17", FULL, 1);
                check("ovf_count_17", COUNT, 16);
`ifdef UART_TX_FIFO_OVF_EN
                check("ovf_flag_pre", OVERFLOW, 0);
`endif
            end
        end
        check("ovf_full_18", FULL, 1);
        check("ovf_count_18", COUNT, 16);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_flag_set", OVERFLOW, 1);
        step();
        check("ovf_flag_sticky", OVERFLOW, 1);
        OVFCLR = 1'b1;
        step();
        OVFCLR = 1'b0;
        check("ovf_flag_clr", OVERFLOW, 0);
`endif
        wait_idle(17 * (FRAME + GAP + 5) + 20);
        check("ovf_starts", starts - s0, 17);
        compare_rx();

        // Wrap-around: three rounds of 12 with a full drain in between.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) push(8'(8'h40 + 16 * r + i), 1);
            wait_idle(12 * (FRAME + GAP + 5) + 20);
            compare_rx();
        end

        // Reset while a frame is in flight.
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 0);
        repeat (3) step();
        check("mid_pre_count", COUNT, 4);
        check("mid_pre_idle", IDLE, 0);
        #1;
        NRESET = 1'b0;
        #1;
        check("mid_count", COUNT, 0);
        check("mid_txstart", TXSTART, 0);
        check("mid_empty", EMPTY, 1);
        check("mid_txdata", TXDATA, 8'h00);
        check("mid_idle", IDLE, 1);
        step();
        NRESET = 1'b1;
        rxq.delete();
        expq.delete();
        s0 = starts;
        repeat (2 * FRAME + 10) step();
        check("mid_no_start", starts - s0, 0);
        check("mid_empty_after", EMPTY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
